// File: rtl/uart_rx_line_ctrl.sv
// Line assembler between the 8N1 UART receiver and the PDU command parser.
// Collects bytes up to TERM_CHAR, holds the line for a valid/ack consumer, and flags overflow and timeout.
module uart_rx_line_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  TERM_CHAR = 8'h0A,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         rx_en,
  input  logic                         rx_ready,
  input  logic [7:0]                   rx_data,
  output logic                         line_valid,
  output logic [$clog2(DEPTH+1)-1:0]   line_len,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         line_ack,
  output logic                         err_ovf,
  output logic                         err_tmo,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]       state, state_nxt;
  logic             rdy_q;
  logic [LEN_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [LEN_W-1:0] line_len_nxt;
  logic             line_valid_nxt;
  logic             err_ovf_nxt, err_tmo_nxt;
  logic [7:0]       drop_cnt_nxt;
  logic             mem_we;
  logic             byte_evt;
  logic [7:0]       line_mem [DEPTH];

  // One event per frame: rising edge of the receiver's ready level
  assign byte_evt = rx_ready & ~rdy_q;
  assign rd_data  = line_mem[rd_addr];

  // Next-state and next-value logic
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    timer_nxt      = timer;
    line_len_nxt   = line_len;
    line_valid_nxt = line_valid;
    err_ovf_nxt    = 1'b0;
    err_tmo_nxt    = 1'b0;
    drop_cnt_nxt   = drop_cnt;
    mem_we         = 1'b0;

    if (!enable) begin
      state_nxt      = S_OFF;
      wr_ptr_nxt     = '0;
      timer_nxt      = '0;
      line_len_nxt   = '0;
      line_valid_nxt = 1'b0;
    end else begin
      case (state)
        S_OFF: state_nxt = S_COLLECT;

        S_COLLECT: begin
          if (byte_evt) begin
            timer_nxt = '0;
            if (rx_data == TERM_CHAR) begin
              line_len_nxt   = wr_ptr;
              line_valid_nxt = 1'b1;
              wr_ptr_nxt     = '0;
              state_nxt      = S_HOLD;
            end else if (wr_ptr == LEN_W'(DEPTH)) begin
              err_ovf_nxt = 1'b1;
              wr_ptr_nxt  = '0;
              state_nxt   = S_DISCARD;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + LEN_W'(1);
            end
          end else if ((TIMEOUT != 0) && (wr_ptr != '0)) begin
            // Idle timer only runs while a partial line is buffered
            if (timer == TMO_LAST) begin
              err_tmo_nxt = 1'b1;
              wr_ptr_nxt  = '0;
              timer_nxt   = '0;
            end else begin
              timer_nxt = timer + TMR_W'(1);
            end
          end
        end

        S_DISCARD: begin
          if (byte_evt && (rx_data == TERM_CHAR)) state_nxt = S_COLLECT;
        end

        S_HOLD: begin
          if (byte_evt && (drop_cnt != 8'hFF)) drop_cnt_nxt = drop_cnt + 8'd1;
          if (line_ack) begin
            line_valid_nxt = 1'b0;
            line_len_nxt   = '0;
            state_nxt      = S_COLLECT;
          end
        end

        default: state_nxt = S_OFF;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_OFF;
      rx_en      <= 1'b0;
      rdy_q      <= 1'b1;
      wr_ptr     <= '0;
      timer      <= '0;
      line_len   <= '0;
      line_valid <= 1'b0;
      err_ovf    <= 1'b0;
      err_tmo    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      rx_en      <= (state_nxt != S_OFF);
      rdy_q      <= rx_ready;
      wr_ptr     <= wr_ptr_nxt;
      timer      <= timer_nxt;
      line_len   <= line_len_nxt;
      line_valid <= line_valid_nxt;
      err_ovf    <= err_ovf_nxt;
      err_tmo    <= err_tmo_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

  // Line storage, contents never reset
  always_ff @(posedge clk) begin
    if (mem_we) line_mem[wr_ptr[AW-1:0]] <= rx_data;
  end

endmodule
